bitplane_packer: RTL and testbench
==================================

// Module: bitplane_packer
// PURPOSE
//  Upstream feeder of the SRAM write port (DATA/DATA_VLD/DATA_HSYNC/DATA_SOP/WREADY).
//  Accepts one pixel position per handshake: DW channels x 8-bit pixels.
//  Emits the position as 8 DW-bit bit-plane beats, flagging frame start (SOP) and row end (HSYNC).
//  Paces beats with a minimum gap and WREADY backpressure so the downstream bank writer never overruns.
// PARAMETERS
//  DW        128  channels per pixel position = bit-plane beat width
//  BEAT_GAP  5    min idle cycles before each beat (>=1)
// PORTS
//  SYS_CLK      in   1      clock
//  SYS_RST      in   1      reset, asynchronous, active-high
//  PIX_IN       in   DW*8   channel c pixel at [8c+:8]
//  PIX_VLD      in   1      PIX_IN valid
//  PIX_SOF      in   1      qualifies the accepted pixel as frame pixel (0,0)
//  PIX_RDY      out  1      block can accept a pixel (IDLE only)
//  PIC_SIZE     in   8      frame is PIC_SIZE x PIC_SIZE positions; sampled at SOF
//  WREADY       in   1      downstream can take a beat
//  DATA         out  DW     bit-plane beat: DATA[c] = pixel_c[plane]
//  DATA_VLD     out  1      1-cycle beat strobe
//  DATA_HSYNC   out  1      1-cycle pulse after last beat of a row's last pixel
//  DATA_SOP     out  1      1-cycle pulse before first beat of a frame
//  FRAME_DONE   out  1      1-cycle pulse, coincident with the HSYNC of the last row
//  ERR          out  1      1-cycle pulse: bad PIC_SIZE, truncated frame, or orphan pixel
// BEHAVIOUR
//  Reset (async): all outputs 0, including PIX_RDY. FSM=IDLE; col/row/plane/gap counters 0; frame_act=0.
//  PIX_RDY rises on the first edge after reset release. All outputs registered.
//  FSM states: IDLE, SOP, GAP, BEAT, HSYNC.
//  IDLE: PIX_RDY=1. On PIX_VLD&PIX_RDY, PIX_IN is latched into the pixel register; PIX_RDY drops next cycle.
//   - SOF=1, PIC_SIZE>=3: latch size; col=row=0; frame_act=1; ->SOP.
//     If frame_act was already 1 (col|row!=0), also pulse ERR (truncated frame).
//   - SOF=1, PIC_SIZE<3: pixel dropped, ERR pulse, stay IDLE.
//   - SOF=0, frame_act=0: pixel dropped, ERR pulse, stay IDLE.
//   - SOF=0, frame_act=1: ->GAP.
//  SOP: DATA_SOP=1 for exactly one cycle; ->GAP.
//  GAP: count BEAT_GAP cycles. On the last gap cycle or later, WREADY=1 sampled -> BEAT; else hold.
//   WREADY sampled 1 obliges downstream to accept the beat in the next cycle.
//  BEAT: DATA_VLD=1 for one cycle; DATA = plane p of all DW channels; p++.
//   - p<7: ->GAP.
//   - p==7, col<size-1: col++; ->IDLE.
//   - p==7, col==size-1: ->HSYNC.
//  HSYNC: DATA_HSYNC=1 for one cycle; col=0.
//   - row<size-1: row++.
//   - row==size-1: FRAME_DONE=1, frame_act=0, row=0.
//   ->IDLE.
//  DATA holds its last value outside BEAT (don't-care when DATA_VLD=0).
//  Latency, WREADY held 1, no SOF:
//   - accept on edge t -> first DATA_VLD in cycle t+BEAT_GAP.
//   - beat spacing is BEAT_GAP+1 cycles.
//   - PIX_RDY high again the cycle after the 8th beat (after HSYNC on row end).
//  With SOF: one extra cycle (SOP) before the first GAP.
//  WREADY low indefinitely: FSM parks in GAP; no beat lost; PIX_RDY stays 0.
//  PIC_SIZE changes mid-frame are ignored; only the value latched at SOF is used.
//  col/row are 8-bit; size 255 max, so no wrap within a frame.
// CONFIGURATION
//  BP_MSB_FIRST_EN defined:   planes emitted 7,6,...,0; last beat of a pixel is plane 0.
//  BP_MSB_FIRST_EN undefined: planes emitted 0,1,...,7 (LSB first), the default the SRAM writer expects.
// TESTING
//  1. Reset; SOF pixel all channels 0x05; PIC_SIZE=8; WREADY=1.
//     -> SOP pulse, then 8 beats {128{1}},{0},{1},{0},{0},{0},{0},{0}, each 6 cycles apart.
//  2. Full 8x8 frame, pixel n = n broadcast to all channels.
//     -> 512 beats, 8 HSYNC (one per 8 pixels), FRAME_DONE with the 8th HSYNC, ERR never set.
//  3. WREADY=0 for 40 cycles mid-pixel.
//     -> no DATA_VLD while low; plane sequence resumes intact; beat count still 8.
//  4. PIC_SIZE=2 with SOF -> ERR pulse, no SOP, no beats.
//     Pixel without SOF after reset -> ERR pulse, no beats.
//  5. New SOF after 10 pixels of an 8x8 frame.
//     -> ERR pulse + SOP; next HSYNC after 8 more pixels.
//     Assert SYS_RST mid-beat -> all outputs 0 immediately.
//  6. Rebuild with BP_MSB_FIRST_EN; pixel 0x80 -> first beat {128{1}}, next 7 beats 0.

Source files
------------

// File: rtl/bitplane_packer_if.sv
// Pixel-in / bit-plane-beat-out bundle for bitplane_packer.
// slave = packer side, master = pixel source plus SRAM writer side.
interface bitplane_packer_if #(
  parameter int unsigned DW = 128
);
  logic [DW*8-1:0] PIX_IN;
  logic            PIX_VLD;
  logic            PIX_SOF;
  logic            PIX_RDY;
  logic [7:0]      PIC_SIZE;
  logic            WREADY;
  logic [DW-1:0]   DATA;
  logic            DATA_VLD;
  logic            DATA_HSYNC;
  logic            DATA_SOP;
  logic            FRAME_DONE;
  logic            ERR;

  modport slave (
    input  PIX_IN, PIX_VLD, PIX_SOF, PIC_SIZE, WREADY,
    output PIX_RDY, DATA, DATA_VLD, DATA_HSYNC, DATA_SOP, FRAME_DONE, ERR
  );

  modport master (
    output PIX_IN, PIX_VLD, PIX_SOF, PIC_SIZE, WREADY,
    input  PIX_RDY, DATA, DATA_VLD, DATA_HSYNC, DATA_SOP, FRAME_DONE, ERR
  );
endinterface

// File: rtl/bitplane_packer.sv
// Turns one DW-channel 8-bit pixel position into 8 paced bit-plane beats with SOP/HSYNC framing.
// Define BP_MSB_FIRST_EN to emit planes 7..0; default order is 0..7.
module bitplane_packer #(
  parameter int unsigned DW       = 128,
  parameter int unsigned BEAT_GAP = 5
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  bitplane_packer_if.slave    bus
);
  localparam int unsigned PW = DW * 8;
  localparam int unsigned GW = (BEAT_GAP < 2) ? 1 : $clog2(BEAT_GAP);

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_GAP, S_BEAT, S_HSYNC} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pix_q;
  logic [7:0]      size_q, col_q, row_q;
  logic [2:0]      plane_q, plane_sel;
  logic [GW-1:0]   gap_q;
  logic            frame_act_q;

  logic            pix_rdy_q, data_vld_q, hsync_q, sop_q, done_q, err_q;
  logic [DW-1:0]   data_q;

  logic            accept_c, gap_last_c, err_c;
  logic [7:0]      size_last_c;
  logic [DW-1:0]   beat_c;
  logic [7:0]      px8;

  assign accept_c    = (state == S_IDLE) && pix_rdy_q && bus.PIX_VLD;
  assign gap_last_c  = (gap_q == GW'(BEAT_GAP - 1));
  assign size_last_c = size_q - 8'd1;

`ifdef BP_MSB_FIRST_EN
  assign plane_sel = 3'd7 - plane_q;
`else
  assign plane_sel = plane_q;
`endif

  // Gather bit plane_sel of every channel into one beat
  always_comb begin
    beat_c = '0;
    px8    = '0;
    for (int c = 0; c < DW; c++) begin
      px8       = pix_q[8*c +: 8];
      beat_c[c] = px8[plane_sel];
    end
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (bus.PIX_SOF) begin
            if (bus.PIC_SIZE >= 8'd3) begin
              state_nxt = S_SOP;
              err_c     = frame_act_q;
            end else begin
              err_c = 1'b1;
            end
          end else if (frame_act_q) begin
            state_nxt = S_GAP;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      S_SOP:   state_nxt = S_GAP;
      S_GAP:   if (gap_last_c && bus.WREADY) state_nxt = S_BEAT;
      S_BEAT: begin
        if (plane_q != 3'd7)          state_nxt = S_GAP;
        else if (col_q != size_last_c) state_nxt = S_IDLE;
        else                           state_nxt = S_HSYNC;
      end
      S_HSYNC: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters, pixel latch and registered outputs derived from the upcoming state
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      pix_q       <= '0;
      size_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      plane_q     <= '0;
      gap_q       <= '0;
      frame_act_q <= 1'b0;
      pix_rdy_q   <= 1'b0;
      data_vld_q  <= 1'b0;
      hsync_q     <= 1'b0;
      sop_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      pix_rdy_q  <= (state_nxt == S_IDLE);
      data_vld_q <= (state_nxt == S_BEAT);
      sop_q      <= (state_nxt == S_SOP);
      hsync_q    <= (state_nxt == S_HSYNC);
      done_q     <= (state_nxt == S_HSYNC) && (row_q == size_last_c);
      err_q      <= err_c;
      if (state_nxt == S_BEAT) data_q <= beat_c;
      if (accept_c)            pix_q  <= bus.PIX_IN;

      if (state == S_GAP) begin
        if (!gap_last_c) gap_q <= gap_q + GW'(1);
      end else begin
        gap_q <= '0;
      end

      case (state)
        S_IDLE: begin
          if (accept_c && bus.PIX_SOF && (bus.PIC_SIZE >= 8'd3)) begin
            size_q      <= bus.PIC_SIZE;
            col_q       <= '0;
            row_q       <= '0;
            frame_act_q <= 1'b1;
          end
        end
        S_BEAT: begin
          plane_q <= plane_q + 3'd1;
          if ((plane_q == 3'd7) && (col_q != size_last_c)) col_q <= col_q + 8'd1;
        end
        S_HSYNC: begin
          col_q <= '0;
          if (row_q != size_last_c) begin
            row_q <= row_q + 8'd1;
          end else begin
            row_q       <= '0;
            frame_act_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PIX_RDY    = pix_rdy_q;
  assign bus.DATA       = data_q;
  assign bus.DATA_VLD   = data_vld_q;
  assign bus.DATA_HSYNC = hsync_q;
  assign bus.DATA_SOP   = sop_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.ERR        = err_q;
endmodule

// File: tb/tb_bitplane_packer.sv
// Scoreboard bench for bitplane_packer: stimulus pushes expected events, a negedge monitor pops them.
module tb_bitplane_packer;
  localparam int unsigned DW = 128;
  localparam int unsigned PW = DW * 8;
  localparam int unsigned BG = 5;

  typedef enum int {EV_ERR, EV_SOP, EV_BEAT, EV_HSYNC} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [DW-1:0] data;
    logic          done;
  } ev_t;

  logic SYS_CLK = 1'b0;
  logic SYS_RST = 1'b1;

  bitplane_packer_if #(.DW(DW)) bus ();

  bitplane_packer #(.DW(DW), .BEAT_GAP(BG)) dut (
    .SYS_CLK (SYS_CLK),
    .SYS_RST (SYS_RST),
    .bus     (bus.slave)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0, errors = 0, cyc = 0;
  int beat_cnt = 0, hsync_cnt = 0, done_cnt = 0, err_cnt = 0;
  ev_t q[$];
  int  beat_cyc[$];

  always @(posedge SYS_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_beat(input logic [PW-1:0] px, input int i);
    logic [DW-1:0] r;
    logic [7:0]    p8;
    int            pl;
`ifdef BP_MSB_FIRST_EN
    pl = 7 - i;
`else
    pl = i;
`endif
    r = '0;
    for (int c = 0; c < DW; c++) begin
      p8   = px[8*c +: 8];
      r[c] = p8[pl];
    end
    return r;
  endfunction

  task automatic check_ev(input ev_kind_t k, input logic [DW-1:0] d, input logic dn);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s actual=%0h required=no_event", k.name(), d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || (k == EV_BEAT && e.data !== d) || (k == EV_HSYNC && e.done !== dn)) begin
        errors++;
        $display("FAIL event actual=%s %0h done=%0b required=%s %0h done=%0b",
                 k.name(), d, dn, e.kind.name(), e.data, e.done);
      end
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queue
  always @(negedge SYS_CLK) begin
    if (!SYS_RST) begin
      if (bus.ERR) begin
        err_cnt++;
        check_ev(EV_ERR, '0, 1'b0);
      end
      if (bus.DATA_SOP) check_ev(EV_SOP, '0, 1'b0);
      if (bus.DATA_VLD) begin
        beat_cnt++;
        beat_cyc.push_back(cyc);
        check_ev(EV_BEAT, bus.DATA, 1'b0);
      end
      if (bus.DATA_HSYNC) begin
        hsync_cnt++;
        check_ev(EV_HSYNC, '0, bus.FRAME_DONE);
      end
      if (bus.FRAME_DONE) begin
        done_cnt++;
        chk("done_with_hsync", DW'(bus.DATA_HSYNC), DW'(1));
      end
    end
  end

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.PIX_RDY && n < 500) begin
      tick();
      n++;
    end
    if (!bus.PIX_RDY) chk("pix_rdy_timeout", DW'(0), DW'(1));
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beat_cnt < target && n < 400) begin
      tick();
      n++;
    end
    if (beat_cnt < target) chk("beat_timeout", DW'(beat_cnt), DW'(target));
  endtask

  task automatic send_pixel(input logic [PW-1:0] px, input logic sof, input logic [7:0] size,
                            input bit e_err, input bit e_sop, input bit e_beats,
                            input bit e_hs, input bit e_done, output int t_acc);
    ev_t e;
    wait_rdy();
    if (e_err) begin e.kind = EV_ERR; e.data = '0; e.done = 1'b0; q.push_back(e); end
    if (e_sop) begin e.kind = EV_SOP; e.data = '0; e.done = 1'b0; q.push_back(e); end
    if (e_beats) begin
      for (int i = 0; i < 8; i++) begin
        e.kind = EV_BEAT; e.data = exp_beat(px, i); e.done = 1'b0; q.push_back(e);
      end
    end
    if (e_hs) begin e.kind = EV_HSYNC; e.data = '0; e.done = e_done; q.push_back(e); end
    bus.PIX_IN   = px;
    bus.PIX_SOF  = sof;
    bus.PIC_SIZE = size;
    bus.PIX_VLD  = 1'b1;
    t_acc = cyc + 1;
    tick();
    bus.PIX_VLD = 1'b0;
    bus.PIX_SOF = 1'b0;
  endtask

  task automatic drain();
    wait_rdy();
    repeat (3) tick();
    chk("queue_empty", DW'(q.size()), DW'(0));
  endtask

  task automatic do_reset();
    SYS_RST     = 1'b1;
    bus.PIX_VLD = 1'b0;
    bus.WREADY  = 1'b1;
    repeat (2) tick();
    q.delete();
    SYS_RST = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, b0, h0, d0, e0, n0;
    bit rdy_seen;
    logic [PW-1:0] ramp;

    bus.PIX_IN = '0; bus.PIX_VLD = 1'b0; bus.PIX_SOF = 1'b0;
    bus.PIC_SIZE = 8'd0; bus.WREADY = 1'b1;
    repeat (2) tick();
    chk("reset_ctrl", DW'({bus.PIX_RDY, bus.DATA_VLD, bus.DATA_HSYNC, bus.DATA_SOP,
                           bus.FRAME_DONE, bus.ERR}), DW'(0));
    chk("reset_data", bus.DATA, DW'(0));
    SYS_RST = 1'b0;
    chk("pix_rdy_at_release", DW'(bus.PIX_RDY), DW'(0));
    tick();
    chk("pix_rdy_first_edge", DW'(bus.PIX_RDY), DW'(1));

    // 1: SOF pixel 0x05, SOP then 8 beats spaced BG+1; second pixel 0x80 without SOF
    b0 = beat_cnt;
    send_pixel({DW{8'h05}}, 1'b1, 8'd8, 0, 1, 1, 0, 0, t);
    chk("pix_rdy_drop", DW'(bus.PIX_RDY), DW'(0));
    wait_beats(b0 + 8);
    chk("sof_first_beat_latency", DW'(beat_cyc[b0] - t), DW'(BG + 1));
    for (int i = 1; i < 8; i++)
      chk("beat_spacing", DW'(beat_cyc[b0+i] - beat_cyc[b0+i-1]), DW'(BG + 1));
    chk("rdy_after_8th_beat", DW'(bus.PIX_RDY), DW'(1));
    chk("rdy_cycle", DW'(cyc), DW'(beat_cyc[b0+7] + 1));
    send_pixel({DW{8'h80}}, 1'b0, 8'd8, 0, 0, 1, 0, 0, t);
    wait_beats(b0 + 9);
    chk("plain_first_beat_latency", DW'(beat_cyc[b0+8] - t), DW'(BG));
    drain();

    // 2: full 8x8 frame, pixel n = n; non-SOF PIC_SIZE changes are ignored
    do_reset();
    b0 = beat_cnt; h0 = hsync_cnt; d0 = done_cnt; e0 = err_cnt;
    for (int n = 0; n < 64; n++)
      send_pixel({DW{8'(n)}}, n == 0, (n == 0) ? 8'd8 : 8'd3, 0, n == 0, 1,
                 (n % 8) == 7, n == 63, t);
    drain();
    chk("frame_beats", DW'(beat_cnt - b0), DW'(512));
    chk("frame_hsyncs", DW'(hsync_cnt - h0), DW'(8));
    chk("frame_done", DW'(done_cnt - d0), DW'(1));
    chk("frame_no_err", DW'(err_cnt - e0), DW'(0));

    // 3: WREADY low for 40 cycles after the third beat
    do_reset();
    for (int c = 0; c < DW; c++) ramp[8*c +: 8] = 8'(c);
    b0 = beat_cnt;
    send_pixel(ramp, 1'b1, 8'd3, 0, 1, 1, 0, 0, t);
    wait_beats(b0 + 3);
    bus.WREADY = 1'b0;
    tick();
    n0 = beat_cnt;
    rdy_seen = 1'b0;
    repeat (39) begin
      tick();
      if (bus.PIX_RDY) rdy_seen = 1'b1;
    end
    chk("no_beat_while_blocked", DW'(beat_cnt), DW'(n0));
    chk("rdy_low_while_blocked", DW'(rdy_seen), DW'(0));
    bus.WREADY = 1'b1;
    drain();
    chk("blocked_pixel_beats", DW'(beat_cnt - b0), DW'(8));

    // 4: bad size and orphan pixel are dropped with ERR
    do_reset();
    b0 = beat_cnt; e0 = err_cnt;
    send_pixel({DW{8'hAA}}, 1'b1, 8'd2, 1, 0, 0, 0, 0, t);
    chk("rdy_after_drop", DW'(bus.PIX_RDY), DW'(1));
    send_pixel({DW{8'h11}}, 1'b0, 8'd8, 1, 0, 0, 0, 0, t);
    drain();
    chk("drop_no_beats", DW'(beat_cnt - b0), DW'(0));
    chk("drop_err_count", DW'(err_cnt - e0), DW'(2));

    // 5: restart after 10 pixels, then reset in the middle of a beat
    do_reset();
    for (int n = 0; n < 10; n++)
      send_pixel({DW{8'(n)}}, n == 0, 8'd8, 0, n == 0, 1, n == 7, 0, t);
    send_pixel({DW{8'h3C}}, 1'b1, 8'd8, 1, 1, 1, 0, 0, t);
    for (int n = 1; n < 8; n++)
      send_pixel({DW{8'(n)}}, 1'b0, 8'd8, 0, 0, 1, n == 7, 0, t);
    drain();
    send_pixel({DW{8'hFF}}, 1'b0, 8'd8, 0, 0, 1, 0, 0, t);
    n0 = 0;
    while (!bus.DATA_VLD && n0 < 100) begin
      tick();
      n0++;
    end
    chk("beat_before_reset", DW'(bus.DATA_VLD), DW'(1));
    SYS_RST = 1'b1;
    #1;
    chk("midbeat_reset_ctrl", DW'({bus.PIX_RDY, bus.DATA_VLD, bus.DATA_HSYNC, bus.DATA_SOP,
                                   bus.FRAME_DONE, bus.ERR}), DW'(0));
    chk("midbeat_reset_data", bus.DATA, DW'(0));
    q.delete();
    repeat (2) tick();
    SYS_RST = 1'b0;
    repeat (3) tick();
    chk("post_reset_rdy", DW'(bus.PIX_RDY), DW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
